uart_tx: RTL and testbench
==========================

# uart_tx

UART serial transmitter; the transmit end of the link whose receive side and baud generator (a `mod_m_counter` producing a 16x-oversampling `max_tick`) already exist. It accepts one parallel byte per request and shifts it out as a standard 8N1 frame (start bit, data bits LSB first, stop bit), timing every bit by counting oversampling ticks. It sits between the baud-rate `mod_m_counter` and the board TX pin; the top level wires `max_tick` to `s_tick`.

## Interface
- `DBIT`, 8: data bits per frame. Legal values are 7 and 8.
- `SB_TICK`, 16: s_tick periods in the stop phase. 16, 24 and 32 give 1, 1.5 and 2 stop bits.
- `clk`  in  1: system clock. Everything is synchronous to its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `s_tick`  in  1: one-cycle enable pulse at 16x the baud rate, driven by `mod_m_counter` `max_tick`.
- `tx_start`  in  1: level request to send `din`. Sampled only in IDLE.
- `din`  in  DBIT: byte to send. Captured on the accepting edge.
- `tx`  out  1: serial line. Registered; idle level is 1.
- `tx_busy`  out  1: high in every state except IDLE.
- `tx_done_tick`  out  1: one-cycle pulse at the end of the stop phase.

## Operation
- Reset values: `tx`=1, `tx_busy`=0, `tx_done_tick`=0, state=IDLE, `s`=0, `n`=0, `b`=0.
- Reset mid-frame: on the next edge, all outputs and state return to their reset values. The frame is abandoned and no `tx_done_tick` is issued.
- Tick counter `s` is 5 bits. Data-bit counter `n` is 3 bits. Shift register `b` is DBIT bits.
- **IDLE**: `tx`=1.
  - If `tx_start`=1, latch `din` into `b`, set `s`=0 and go to START.
  - `s_tick` is irrelevant in IDLE.
- **START**: `tx`=0.
  - On each `s_tick`, increment `s`.
  - On the `s_tick` with `s`=15: set `s`=0, `n`=0 and go to DATA.
- **DATA**: `tx`=`b[0]`.
  - On each `s_tick`, increment `s`.
  - On the `s_tick` with `s`=15: set `s`=0 and shift `b` right by one.
  - At that same point, if `n`=DBIT-1 go to STOP; otherwise increment `n`.
- **STOP**: `tx`=1.
  - On each `s_tick`, increment `s`.
  - On the `s_tick` with `s`=SB_TICK-1: assert `tx_done_tick` for one cycle and go to IDLE.
- `tx_start` outside IDLE is ignored. `din` changes outside IDLE have no effect.
- `tx_start` held high causes back-to-back frames. The next frame is accepted on the first cycle in IDLE, i.e. the cycle after `tx_done_tick`.
- No timeout: if `s_tick` never arrives, the FSM holds its current state indefinitely.

## Timing
- `tx` is registered. It takes the new phase value on the clock edge after the state change.
  - Start bit: `tx` falls one `clk` after the accepting edge.
- Bit duration is exactly 16 `s_tick` periods. The exception is the start bit, which lasts 15 to 16 `s_tick` periods because `s_tick` phase is unaligned at acceptance.
- Frame duration: (1 + DBIT) × 16 + SB_TICK ticks, with the same start-bit tolerance.
- `tx_done_tick` is asserted in the same cycle the state returns to IDLE. `tx_busy` falls in that same cycle.
- `s_tick` and a state transition on the same edge:
  - Exactly one increment or transition occurs per `s_tick`.
  - A tick arriving on the edge that enters START counts toward nothing. `s` is cleared on entry.

## Structure
- Shared package `uart_pkg`:
  - state enum `uart_state_t` {IDLE, START, DATA, STOP};
  - `OVERSAMPLE`=16;
  - default `DBIT` and `SB_TICK` values, shared with the receiver.
- Sub-module `uart_tx_top`: instantiates `mod_m_counter` (M=163 for 19200 baud from 50 MHz) and `uart_tx`.
- The transmitter itself is a single FSM module with a separate next-state block.

## Test plan
- Reset held for 2 cycles → `tx`=1, `tx_busy`=0, `tx_done_tick`=0 throughout reset and afterwards while idle.
- `s_tick` every 4 clocks; `din`=0xA5; 1-cycle `tx_start`:
  - `tx` bit sequence is 0,1,0,1,0,0,1,0,1,1, each bit 64 clocks (start bit 60–64).
  - Exactly one `tx_done_tick`, 640±4 clocks after acceptance.
- Mid-frame `tx_start` with `din`=0x3C during DATA → ignored; the frame on the line still decodes 0xA5 and no extra frame follows.
- `tx_start` held high, `din`=0x55 → two frames back-to-back; the second start bit falls 1 clock after the first `tx_done_tick`.
- `reset` asserted during data bit 3 → `tx`=1 on the next edge, no `tx_done_tick`. A new 0x81 request after reset transmits correctly.
- `s_tick` held low after accept → `tx` stays 0 and `tx_busy` stays 1 for 1000 clocks. Ticks then resume and the frame completes normally.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_pkg                                                       |
// | Purpose  : Shared UART definitions: FSM state encoding, oversampling      |
// |            ratio and default frame format for the transmitter and the    |
// |            receiver.                                                     |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package uart_pkg;

  // Frame phases; both ends of the link walk through the same sequence.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // s_tick pulses per bit period (16x oversampling).
  localparam int OVERSAMPLE      = 16;

  // Default 8N1 with one stop bit.
  localparam int DEFAULT_DBIT    = 8;
  localparam int DEFAULT_SB_TICK = 16;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_tx                                                        |
// | Purpose  : UART serial transmitter. Accepts one parallel word per request |
// |            and shifts it out as start bit, DBIT data bits LSB first, and |
// |            a stop phase of SB_TICK oversampling ticks.                   |
// | Ports    : clk          - system clock, rising edge                      |
// |            reset        - synchronous active-high reset                  |
// |            s_tick       - 16x baud enable pulse                          |
// |            tx_start     - level request to send din (sampled in IDLE)    |
// |            din          - word to send, captured on the accepting edge   |
// |            tx           - registered serial line, idles high             |
// |            tx_busy      - high whenever the FSM is not in IDLE           |
// |            tx_done_tick - one-cycle pulse as the stop phase completes    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT    = DEFAULT_DBIT,
  parameter int SB_TICK = DEFAULT_SB_TICK
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam logic [4:0] C_S_LAST  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] C_SB_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] C_N_LAST  = 3'(DBIT - 1);

  uart_state_t     state_q, state_d;
  logic [4:0]      s_q, s_d;       // oversampling tick counter
  logic [2:0]      n_q, n_d;       // data bit counter
  logic [DBIT-1:0] b_q, b_d;       // shift register, LSB goes out first
  logic            tx_q, tx_d;
  logic            done_q, done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  // tx_d is the line level of the current phase, so the registered line
  // follows each state change one clock later.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    done_d  = 1'b0;
    tx_d    = 1'b1;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_start) begin
          b_d     = din;
          s_d     = '0;
          state_d = START;
        end
      end

      START: begin
        tx_d = 1'b0;
        if (s_tick) begin
          if (s_q == C_S_LAST) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end

      DATA: begin
        tx_d = b_q[0];
        if (s_tick) begin
          if (s_q == C_S_LAST) begin
            s_d = '0;
            b_d = {1'b0, b_q[DBIT-1:1]};
            if (n_q == C_N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end

      STOP: begin
        tx_d = 1'b1;
        if (s_tick) begin
          if (s_q == C_SB_LAST) begin
            s_d     = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign tx           = tx_q;
  assign tx_busy      = (state_q != IDLE);
  assign tx_done_tick = done_q;

endmodule : uart_tx
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_tx                                                     |
// | Purpose  : Self-checking bench for uart_tx: table of frames plus         |
// |            hand-written back-to-back, reset and stalled-tick sequences.  |
// | Ports    : none                                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_uart_tx;

  logic       clk;
  logic       reset;
  logic       s_tick;
  logic       tx_start;
  logic [7:0] din;
  logic       tx;
  logic       tx_busy;
  logic       tx_done_tick;

  int checks = 0;
  int errors = 0;

  logic tick_en;
  int   tick_cnt;

  uart_tx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .tx_start     (tx_start),
    .din          (din),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // s_tick: one pulse every 4 clocks while enabled, driven on the falling edge.
  initial begin
    s_tick   = 1'b0;
    tick_cnt = 0;
  end
  always @(negedge clk) begin
    if (tick_en) begin
      s_tick   = (tick_cnt == 3);
      tick_cnt = (tick_cnt + 1) % 4;
    end else begin
      s_tick = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // Request a frame; returns on the falling edge just after the accepting edge.
  task automatic send(input logic [7:0] d, input bit hold);
    @(negedge clk);
    din      = d;
    tx_start = 1'b1;
    @(negedge clk);
    if (!hold) begin
      tx_start = 1'b0;
      din      = 8'h00;
    end
  endtask

  // Decode one frame; called at offset 0 (falling edge after acceptance).
  // Bit i is sampled 30+64*i clocks in, mid-bit for any start-bit length 60..65.
  // Returns on the falling edge where tx_done_tick is seen (or after 700 clocks).
  task automatic monitor(input string tag, input logic [9:0] exp, input bit fresh,
                         input bit inject, input logic [7:0] inj_d);
    logic [9:0] frame;
    int         done_at;
    int         bad_busy;
    int         idx;
    frame    = '0;
    done_at  = -1;
    bad_busy = 0;
    chk({tag, "_busy_on_accept"}, 32'(tx_busy), 32'd1);
    if (fresh) chk({tag, "_tx_high_at_accept"}, 32'(tx), 32'd1);
    for (int t = 1; t <= 700 && done_at < 0; t++) begin
      @(negedge clk);
      if (t == 1) chk({tag, "_start_fall"}, 32'(tx), 32'd0);
      if (inject && t == 200) begin
        din      = inj_d;
        tx_start = 1'b1;
      end
      if (inject && t == 201) begin
        tx_start = 1'b0;
      end
      if (t >= 30 && ((t - 30) % 64) == 0) begin
        idx = (t - 30) / 64;
        if (idx < 10) frame[idx] = tx;
      end
      if (tx_done_tick === 1'b1) done_at = t;
      else if (tx_busy !== 1'b1) bad_busy++;
    end
    chk({tag, "_frame"}, 32'(frame), 32'(exp));
    chk_range({tag, "_done_time"}, done_at, 636, 644);
    chk({tag, "_busy_during_frame"}, 32'(bad_busy), 32'd0);
    chk({tag, "_busy_low_at_done"}, 32'(tx_busy), 32'd0);
  endtask

  // Line must sit idle: tx high, not busy, no done pulse.
  task automatic quiet(input string tag, input int n);
    int bad;
    bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done_tick !== 1'b0) bad++;
    end
    chk({tag, "_idle"}, 32'(bad), 32'd0);
  endtask

  typedef struct {
    logic [7:0] d;
    bit         inject;
    logic [7:0] inj_d;
    logic [9:0] exp_frame;   // bit i = i-th symbol on the line
  } vec_t;

  vec_t vecs [5];

  initial begin
    int bad;

    // {stop, data[7:0], start} written out by hand
    vecs[0] = '{8'hA5, 1'b0, 8'h00, 10'h34A};
    vecs[1] = '{8'h00, 1'b0, 8'h00, 10'h200};
    vecs[2] = '{8'hFF, 1'b0, 8'h00, 10'h3FE};
    vecs[3] = '{8'hA5, 1'b1, 8'h3C, 10'h34A};
    vecs[4] = '{8'h81, 1'b0, 8'h00, 10'h302};

    reset    = 1'b1;
    tick_en  = 1'b1;
    tx_start = 1'b0;
    din      = 8'h00;

    // Reset held for 2 cycles
    repeat (2) begin
      @(negedge clk);
      chk("reset_tx",   32'(tx),           32'd1);
      chk("reset_busy", 32'(tx_busy),      32'd0);
      chk("reset_done", 32'(tx_done_tick), 32'd0);
    end
    reset = 1'b0;
    quiet("after_reset", 10);

    // Table of single frames
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].d, 1'b0);
      monitor($sformatf("vec%0d", i), vecs[i].exp_frame, 1'b1, vecs[i].inject, vecs[i].inj_d);
      quiet($sformatf("vec%0d_post", i), 64);
    end

    // Back-to-back frames with tx_start held high
    send(8'h55, 1'b1);
    monitor("b2b_first", 10'h2AA, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    chk("b2b_gap_tx",   32'(tx),      32'd1);
    chk("b2b_gap_busy", 32'(tx_busy), 32'd1);
    tx_start = 1'b0;
    din      = 8'h00;
    monitor("b2b_second", 10'h2AA, 1'b0, 1'b0, 8'h00);
    quiet("b2b_post", 64);

    // Reset during data bit 3 abandons the frame
    send(8'hA5, 1'b0);
    repeat (286) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_tx",   32'(tx),           32'd1);
    chk("midreset_busy", 32'(tx_busy),      32'd0);
    chk("midreset_done", 32'(tx_done_tick), 32'd0);
    reset = 1'b0;
    quiet("midreset_post", 100);
    send(8'h81, 1'b0);
    monitor("after_reset_frame", 10'h302, 1'b1, 1'b0, 8'h00);
    quiet("after_reset_frame_post", 64);

    // No ticks after acceptance: FSM must hold in the start bit
    tick_en = 1'b0;
    send(8'h3C, 1'b0);
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b0 || tx_busy !== 1'b1 || tx_done_tick !== 1'b0) bad++;
    end
    chk("stall_hold", 32'(bad), 32'd0);
    tick_en = 1'b1;
    monitor("stall_resume", 10'h278, 1'b0, 1'b0, 8'h00);
    quiet("stall_post", 64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_uart_tx
`default_nettype wire
